// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - front-panel mode/set/increment/chime controller for the BCD time counter
// Optional INC auto-repeat is built when AUTO_REPEAT_EN is defined.
module clock_mode_ctrl #(
    parameter int TIMEOUT_TICKS = 10,
    parameter int CHIME_TICKS   = 3,
    parameter int REPEAT_DELAY  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [15:0] data_in,
    output logic        start,
    output logic        set_ore,
    output logic        set_minute,
    output logic        increment,
    output logic        chime,
    output logic [1:0]  mode_state
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_ORE = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_TICKS - 1);
    localparam logic [3:0] CHIME_LOAD = 4'(CHIME_TICKS);

    generate
        if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255 || CHIME_TICKS < 1 || CHIME_TICKS > 15 ||
            REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_param_check
            $error("clock_mode_ctrl: parameter out of range");
        end
    endgenerate

    state_t      state;
    logic [1:0]  mode_sync;
    logic [1:0]  inc_sync;
    logic        mode_prev;
    logic        inc_prev;
    logic        mode_pulse;
    logic        inc_pulse;
    logic        rep_pulse;
    logic        inc_evt;
    logic        timeout_hit;
    logic [7:0]  to_cnt;
    logic [15:0] prev;
    logic [3:0]  chime_cnt;

    // Two-flop synchronizer, then a registered rising-edge pulse (press visible 3 clocks later).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_sync  <= '0;
            inc_sync   <= '0;
            mode_prev  <= 1'b0;
            inc_prev   <= 1'b0;
            mode_pulse <= 1'b0;
            inc_pulse  <= 1'b0;
        end else begin
            mode_sync  <= {mode_sync[0], btn_mode};
            inc_sync   <= {inc_sync[0], btn_inc};
            mode_prev  <= mode_sync[1];
            inc_prev   <= inc_sync[1];
            mode_pulse <= mode_sync[1] & ~mode_prev;
            inc_pulse  <= inc_sync[1] & ~inc_prev;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [7:0] REP_DELAY = 8'(REPEAT_DELAY);

    logic [7:0] hold_cnt;
    logic       rep_abort;

    // rep_abort latches a MODE press during a hold so the repeat stays off until INC is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            rep_abort <= 1'b0;
            rep_pulse <= 1'b0;
        end else begin
            rep_pulse <= 1'b0;
            if (!inc_sync[1] || state == RUN) begin
                hold_cnt  <= '0;
                rep_abort <= 1'b0;
            end else if (mode_pulse) begin
                hold_cnt  <= '0;
                rep_abort <= 1'b1;
            end else if (tick_1hz && !rep_abort) begin
                if (hold_cnt >= REP_DELAY)
                    rep_pulse <= 1'b1;
                else
                    hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign inc_evt     = inc_pulse | rep_pulse;
    assign timeout_hit = (state != RUN) && tick_1hz && (to_cnt == TO_LAST);
    assign mode_state  = state;
    assign chime       = (chime_cnt != 4'd0);

    // Timeout beats MODE, MODE beats INC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            to_cnt     <= '0;
            start      <= 1'b0;
            set_ore    <= 1'b0;
            set_minute <= 1'b0;
            increment  <= 1'b0;
        end else begin
            start      <= tick_1hz && (state == RUN);
            set_ore    <= (state == SET_ORE);
            set_minute <= (state == SET_MIN);
            increment  <= inc_evt && !mode_pulse && !timeout_hit && (state != RUN);
            if (state == RUN) begin
                to_cnt <= '0;
                if (mode_pulse)
                    state <= SET_ORE;
            end else if (timeout_hit) begin
                state  <= RUN;
                to_cnt <= '0;
            end else if (mode_pulse) begin
                state  <= (state == SET_ORE) ? SET_MIN : RUN;
                to_cnt <= '0;
            end else if (inc_evt) begin
                to_cnt <= '0;
            end else if (tick_1hz) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end

    // Only a real rollover while running chimes; wraps during minute setting are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev      <= '0;
            chime_cnt <= '0;
        end else begin
            prev <= data_in;
            if (state != RUN)
                chime_cnt <= '0;
            else if (data_in == 16'h0000 && prev != 16'h0000)
                chime_cnt <= CHIME_LOAD;
            else if (tick_1hz && chime_cnt != 4'd0)
                chime_cnt <= chime_cnt - 4'd1;
        end
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Front-panel controller for the BCD time counter: turns two debounced push-buttons (MODE, INC) and the 1 Hz tick into the counter's start, set_ore, set_minute and increment controls.
- Sequences the clock through RUN, SET_ORE and SET_MIN, with an inactivity timeout back to RUN.
- Produces an hourly chime from the counter's minute/second data.
- Sits between the button/prescaler logic and the counter; all outputs connect straight to the counter's control inputs.

Parameters:
- TIMEOUT_TICKS, 10, 1 Hz ticks with no button activity in a set state before auto-return to RUN (range 1..255).
- CHIME_TICKS, 3, 1 Hz ticks for which chime stays high after the hour rollover (range 1..15).
- REPEAT_DELAY, 2, ticks INC must be held before auto-repeat starts (AUTO_REPEAT_EN only).

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle enable pulse, once per second.
- btn_mode  in  1  debounced MODE button, asynchronous level, high = pressed.
- btn_inc  in  1  debounced INC button, asynchronous level, high = pressed.
- data_in  in  16  counter min/sec in BCD: [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
- start  out  1  counter run enable.
- set_ore  out  1  hour set mode.
- set_minute  out  1  minute set mode; also clears seconds in the counter.
- increment  out  1  one-cycle increment pulse.
- chime  out  1  hourly chime.
- mode_state  out  2  current state: 00 RUN, 01 SET_ORE, 10 SET_MIN.

Behaviour:
- Reset (reset low, asynchronous): state=RUN; all sync and edge flops cleared; timeout counter=0; chime counter=0.
- Reset values of outputs: start=0, set_ore=0, set_minute=0, increment=0, chime=0, mode_state=00.
- Button input path: 2-FF synchronizer, then rising-edge detect. A press reaches mode_pulse/inc_pulse 3 clocks after the asynchronous edge. Holding a button produces exactly one pulse.
- State transitions on mode_pulse: RUN -> SET_ORE -> SET_MIN -> RUN.
- Timeout: in SET_ORE or SET_MIN, the timeout counter increments on each tick_1hz and clears on any mode_pulse or inc_pulse. When it reaches TIMEOUT_TICKS the state goes to RUN on that cycle. The counter is cleared on entry to any state.
- Outputs (registered, one cycle after state/pulse):
  - start = tick_1hz (registered) AND state==RUN. Counting is frozen in set states.
  - set_ore = state==SET_ORE, as a level.
  - set_minute = state==SET_MIN, as a level.
  - increment = inc_pulse AND state!=RUN, exactly 1 clock wide. inc_pulse in RUN is ignored.
- Simultaneous mode_pulse and inc_pulse: mode wins, the state advances and the increment is dropped.
- mode_pulse coinciding with the timeout: state goes to RUN; the timeout takes priority.
- Chime:
  - Register data_in each clock as prev.
  - In RUN, when data_in==16'h0000 and prev!=16'h0000, load the chime counter with CHIME_TICKS.
  - Each tick_1hz decrements the counter while it is non-zero; chime = (counter!=0).
  - A transition to 0000 in a set state (minute setting wrapping 59->00) does not chime.
  - Leaving RUN clears the chime counter.
- Reset mid-operation: all state is cleared immediately, with no pending increment emitted after release.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: in a set state, if synchronized btn_inc stays high for REPEAT_DELAY ticks, increment pulses once on every subsequent tick_1hz (1 clock wide, registered) until release. Repeat pulses also clear the timeout counter. mode_pulse aborts the repeat.
- Undefined: exactly one increment per press; no hold logic is synthesized.

Test Plan:
- Reset low mid-count -> all outputs 0 and mode_state=00 asynchronously. After release, 5 ticks -> exactly 5 start pulses, each coincident 1 clock after its tick.
- MODE press -> mode_state=01, set_ore=1, start stays 0. Second press -> 10, set_minute=1. Third -> 00 with start resuming.
- SET_ORE, 3 INC presses held 50 clocks each -> exactly 3 increment pulses, each 1 clock wide, first appearing 4 clocks after the press edge. INC press in RUN -> no pulse.
- SET_MIN, no buttons, 10 ticks -> mode_state returns to 00 on the 10th tick. An INC at tick 9 restarts the count, so the return happens at tick 19.
- RUN, data_in goes 5959 -> 0000 -> chime=1 for 3 ticks, then 0. Same transition in SET_MIN -> chime stays 0.
- AUTO_REPEAT_EN, SET_ORE, INC held 6 ticks -> 1 press pulse + 4 repeat pulses. Without the macro -> 1 pulse.
